ber_sequencer: RTL and testbench

Runtime-programmable BER measurement sequencer that supersedes the fixed-count BER control block. It runs the BER measurement through wait/settle, PRBS synchronisation sweep, a finite or free-running count window, and done. It adds a start/restart handshake, sync-lock check with bounded retries, and parametrised PRBS length. It sits between the symbol-rate strobe generator and the PRBS checker / BER counter of one receive lane.

---
 rtl/ber_seq_pkg.sv | 18 +
 rtl/prbs_sweep_counter.sv | 59 +++++
 rtl/ber_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ber_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ber_seq_pkg.sv
// ber_seq_pkg
//   Shared definitions for the BER measurement sequencer: FSM state
//   encoding, width of the exported state code and the default PRBS period.
package ber_seq_pkg;

  localparam int unsigned STATE_W          = 3;
  localparam int unsigned DEFAULT_PRBS_LEN = 511;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SYNC  = 3'd2,
    ST_COUNT = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

endpackage

// File: rtl/prbs_sweep_counter.sv
// prbs_sweep_counter
//   Phase / address counter pair for the PRBS alignment sweep. The phase
//   counter runs 0..PRBS_LEN-1 per enabled cycle; the address counter steps
//   on every phase wrap. Both wrap to 0 after the last alignment.
// Ports:
//   clk, i_reset   clock, synchronous active-high reset
//   i_clear        force both counters to 0 (priority over i_en)
//   i_en           advance by one symbol
//   o_phase_last   phase counter = PRBS_LEN-1
//   o_sweep_last   phase and address counters both = PRBS_LEN-1
module prbs_sweep_counter
  import ber_seq_pkg::*;
#(
  parameter int unsigned PRBS_LEN = DEFAULT_PRBS_LEN
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_phase_last,
  output logic o_sweep_last
);

  localparam int unsigned CNT_W = (PRBS_LEN > 1) ? $clog2(PRBS_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRBS_LEN - 1);

  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase_q <= '0;
      addr_q  <= '0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    if (i_clear) begin
      phase_d = '0;
      addr_d  = '0;
    end else if (i_en) begin
      if (phase_q == LAST) begin
        phase_d = '0;
        addr_d  = (addr_q == LAST) ? '0 : addr_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  assign o_phase_last = (phase_q == LAST);
  assign o_sweep_last = o_phase_last && (addr_q == LAST);

endmodule

// File: rtl/ber_sequencer.sv
// ber_sequencer
//   Runtime-programmable BER measurement sequencer for one receive lane:
//   IDLE -> WAIT (settle) -> SYNC (PRBS alignment sweep, bounded retries)
//   -> COUNT (finite or free-running window) -> DONE, or FAIL on no lock.
// Ports:
//   clk, i_reset                 clock, synchronous active-high reset
//   i_ctrl                       symbol-rate strobe; all counting gated by it
//   i_start                      start/restart, accepted in IDLE/DONE/FAIL
//   i_wait_len                   settle strobes (0 behaves as 1), latched on start
//   i_count_len                  window strobes (0 = infinite), latched on start
//   i_sync_lock                  checker lock, sampled at sweep end
//   o_start_synchro              in SYNC
//   o_prbs_cmp_curr_addr_done    in SYNC on the last phase of an alignment
//   o_start_ber_counter          in COUNT
//   o_done / o_sync_fail         in DONE / FAIL
//   o_state                      current state code
module ber_sequencer
  import ber_seq_pkg::*;
#(
  parameter int unsigned PRBS_LEN   = DEFAULT_PRBS_LEN,
  parameter int unsigned WAIT_W     = 20,
  parameter int unsigned WIN_W      = 32,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned AUTO_START = 0
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_ctrl,
  input  logic               i_start,
  input  logic [WAIT_W-1:0]  i_wait_len,
  input  logic [WIN_W-1:0]   i_count_len,
  input  logic               i_sync_lock,
  output logic               o_start_synchro,
  output logic               o_prbs_cmp_curr_addr_done,
  output logic               o_start_ber_counter,
  output logic               o_done,
  output logic               o_sync_fail,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_len_q, wait_len_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [WIN_W-1:0]   count_len_q, count_len_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               auto_start_q, auto_start_d;

  logic start_acc;
  logic phase_last;
  logic sweep_last;
  logic wait_hit;
  logic win_hit;

  prbs_sweep_counter #(
    .PRBS_LEN (PRBS_LEN)
  ) u_sweep (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_clear      (state_q != ST_SYNC),
    .i_en         ((state_q == ST_SYNC) && i_ctrl),
    .o_phase_last (phase_last),
    .o_sweep_last (sweep_last)
  );

  // auto_start_q is set by reset only, so it fires exactly once: on the
  // first clock after reset release, while the FSM is still in IDLE.
  assign start_acc = i_start || auto_start_q;
  assign wait_hit  = (wait_cnt_q == ((wait_len_q == '0) ? '0 : wait_len_q - 1'b1));
  assign win_hit   = (win_cnt_q == count_len_q - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      wait_len_q   <= '0;
      wait_cnt_q   <= '0;
      count_len_q  <= '0;
      win_cnt_q    <= '0;
      retry_q      <= '0;
      auto_start_q <= (AUTO_START != 0);
    end else begin
      state_q      <= state_d;
      wait_len_q   <= wait_len_d;
      wait_cnt_q   <= wait_cnt_d;
      count_len_q  <= count_len_d;
      win_cnt_q    <= win_cnt_d;
      retry_q      <= retry_d;
      auto_start_q <= auto_start_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d      = state_q;
    wait_len_d   = wait_len_q;
    wait_cnt_d   = wait_cnt_q;
    count_len_d  = count_len_q;
    win_cnt_d    = win_cnt_q;
    retry_d      = retry_q;
    auto_start_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (state_q == ST_IDLE) begin
          wait_cnt_d = '0;
          win_cnt_d  = '0;
          retry_d    = '0;
        end
        if (start_acc) begin
          state_d     = ST_WAIT;
          wait_len_d  = i_wait_len;
          count_len_d = i_count_len;
          wait_cnt_d  = '0;
          retry_d     = '0;
        end
      end
      ST_WAIT: begin
        if (i_ctrl) begin
          if (wait_hit) state_d = ST_SYNC;
          else          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_SYNC: begin
        // The sweep counters wrap to 0 on the last strobe, so a retry
        // restarts the sweep without an explicit clear.
        if (i_ctrl && sweep_last) begin
          if (i_sync_lock) begin
            state_d   = ST_COUNT;
            win_cnt_d = '0;
          end else if (retry_q == RETRY_LAST) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
      end
      ST_COUNT: begin
        if (i_ctrl && (count_len_q != '0)) begin
          if (win_hit) state_d = ST_DONE;
          else         win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs, decoded from registers only
  always_comb begin
    o_start_synchro           = (state_q == ST_SYNC);
    o_prbs_cmp_curr_addr_done = (state_q == ST_SYNC) && phase_last;
    o_start_ber_counter       = (state_q == ST_COUNT);
    o_done                    = (state_q == ST_DONE);
    o_sync_fail               = (state_q == ST_FAIL);
    o_state                   = state_q;
  end

endmodule

// File: tb/tb_ber_sequencer.sv
// tb_ber_sequencer
//   Directed bench for ber_sequencer with PRBS_LEN=7, MAX_RETRY=2. A second
//   instance built with AUTO_START=1 covers the auto-start behaviour.
module tb_ber_sequencer;

  localparam int PL = 7;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        a_reset = 1'b1;
  logic        i_ctrl = 1'b1;
  logic        i_start = 1'b0;
  logic [19:0] i_wait_len = '0;
  logic [31:0] i_count_len = '0;
  logic        i_sync_lock = 1'b0;

  logic       o_start_synchro, o_prbs_cmp_curr_addr_done, o_start_ber_counter;
  logic       o_done, o_sync_fail;
  logic [2:0] o_state;

  logic       a_start_synchro, a_prbs_cmp_curr_addr_done, a_start_ber_counter;
  logic       a_done, a_sync_fail;
  logic [2:0] a_state;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ber_sequencer #(
    .PRBS_LEN   (PL),
    .WAIT_W     (20),
    .WIN_W      (32),
    .MAX_RETRY  (MR),
    .AUTO_START (0)
  ) dut (
    .clk                       (clk),
    .i_reset                   (i_reset),
    .i_ctrl                    (i_ctrl),
    .i_start                   (i_start),
    .i_wait_len                (i_wait_len),
    .i_count_len               (i_count_len),
    .i_sync_lock               (i_sync_lock),
    .o_start_synchro           (o_start_synchro),
    .o_prbs_cmp_curr_addr_done (o_prbs_cmp_curr_addr_done),
    .o_start_ber_counter       (o_start_ber_counter),
    .o_done                    (o_done),
    .o_sync_fail               (o_sync_fail),
    .o_state                   (o_state)
  );

  ber_sequencer #(
    .PRBS_LEN   (PL),
    .WAIT_W     (20),
    .WIN_W      (32),
    .MAX_RETRY  (MR),
    .AUTO_START (1)
  ) dut_auto (
    .clk                       (clk),
    .i_reset                   (a_reset),
    .i_ctrl                    (i_ctrl),
    .i_start                   (1'b0),
    .i_wait_len                (i_wait_len),
    .i_count_len               (i_count_len),
    .i_sync_lock               (i_sync_lock),
    .o_start_synchro           (a_start_synchro),
    .o_prbs_cmp_curr_addr_done (a_prbs_cmp_curr_addr_done),
    .o_start_ber_counter       (a_start_ber_counter),
    .o_done                    (a_done),
    .o_sync_fail               (a_sync_fail),
    .o_state                   (a_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output of the main instance against one expected state.
  task automatic expect_st(input string tag, input int st, input bit ad);
    check_val({tag, ".state"}, 32'(o_state), 32'(st));
    check_val({tag, ".sync"},  32'(o_start_synchro), 32'(st == 2));
    check_val({tag, ".adone"}, 32'(o_prbs_cmp_curr_addr_done), 32'(ad));
    check_val({tag, ".cnt"},   32'(o_start_ber_counter), 32'(st == 3));
    check_val({tag, ".done"},  32'(o_done), 32'(st == 4));
    check_val({tag, ".fail"},  32'(o_sync_fail), 32'(st == 5));
  endtask

  task automatic do_reset(input string tag);
    i_start = 1'b0;
    i_ctrl  = 1'b1;
    i_reset = 1'b1;
    tick();
    tick();
    expect_st({tag, ".rst"}, 0, 1'b0);
    i_reset = 1'b0;
  endtask

  // Start in the current cycle (cycle 0) with i_ctrl=1 every cycle, then
  // check cycles 1..ncyc. The length ports switch to *_mid after the start
  // has been sampled.
  task automatic run_full(input string tag, input int wl, input int cl, input bit lk,
                          input int ncyc, input int wl_mid, input int cl_mid);
    int w, s0, s_end, st;
    bit ad;
    w     = (wl == 0) ? 1 : wl;
    s0    = w + 1;
    s_end = w + PL * PL * (lk ? 1 : MR);
    i_wait_len  = 20'(wl);
    i_count_len = 32'(cl);
    i_sync_lock = lk;
    i_ctrl      = 1'b1;
    i_start     = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (c == 1) begin
        i_start     = 1'b0;
        i_wait_len  = 20'(wl_mid);
        i_count_len = 32'(cl_mid);
      end
      ad = 1'b0;
      if (c <= w) st = 1;
      else if (c <= s_end) begin
        st = 2;
        ad = ((c - s0) % PL) == PL - 1;
      end
      else if (!lk) st = 5;
      else if (cl == 0 || c <= s_end + cl) st = 3;
      else st = 4;
      expect_st($sformatf("%s.c%0d", tag, c), st, ad);
    end
  endtask

  initial begin
    // 1: nominal run with lock
    do_reset("s1");
    run_full("s1", 10, 20, 1'b1, 84, 10, 20);

    // 2: no lock -> FAIL after MR sweeps, then restart
    do_reset("s2");
    run_full("s2", 10, 20, 1'b0, 112, 10, 20);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    expect_st("s2.restart", 1, 1'b0);

    // 3: quarter-rate strobe, outputs stable between strobes
    do_reset("s3");
    i_ctrl      = 1'b0;
    i_wait_len  = 20'd3;
    i_count_len = 32'd20;
    i_sync_lock = 1'b1;
    i_start     = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      tick();
      i_start = 1'b0;
      i_ctrl  = (c % 4 == 0);
      expect_st($sformatf("s3.c%0d", c), (c <= 12) ? 1 : 2, (c >= 37 && c <= 40));
    end
    i_ctrl = 1'b1;

    // 4: infinite window, start pulses ignored in COUNT
    do_reset("s4");
    run_full("s4", 1, 0, 1'b1, 60, 1, 0);
    for (int k = 0; k < 1050; k++) begin
      i_start = (k % 97 == 0);
      tick();
      if (k % 50 == 49) expect_st($sformatf("s4.k%0d", k), 3, 1'b0);
    end
    i_start = 1'b0;

    // 5: reset mid-SYNC, then auto-start instance
    do_reset("s5");
    run_full("s5", 2, 20, 1'b1, 20, 2, 20);
    i_reset = 1'b1;
    tick();
    expect_st("s5.midrst", 0, 1'b0);
    i_reset = 1'b0;
    tick();
    expect_st("s5.idle", 0, 1'b0);
    check_val("s5.auto_rst", 32'(a_state), 32'd0);
    a_reset = 1'b0;
    tick();
    check_val("s5.auto_wait", 32'(a_state), 32'd1);
    check_val("s5.auto_sync0", 32'(a_start_synchro), 32'd0);
    tick();
    check_val("s5.auto_wait2", 32'(a_state), 32'd1);
    tick();
    check_val("s5.auto_sync", 32'(a_state), 32'd2);
    check_val("s5.auto_sync1", 32'(a_start_synchro), 32'd1);

    // 6: lengths latched at start; wait length 0 behaves as 1
    do_reset("s6");
    run_full("s6", 4, 5, 1'b1, 62, 50, 100);
    i_wait_len  = 20'd0;
    i_count_len = 32'd3;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    expect_st("s6.w0_wait", 1, 1'b0);
    tick();
    expect_st("s6.w0_sync", 2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
